// File: rtl/rf_pkg.sv
// Shared constants, opcodes and FSM encoding for the
// register-file operation sequencer.
package rf_pkg;

    localparam int DW = 9;
    localparam int AW = 2;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_ADD = 3'd1,
        OP_SUB = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5,
        OP_MOV = 3'd6,
        OP_LDI = 3'd7
    } op_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_WRITE = 2'd3;

endpackage

// File: rtl/rf_alu.sv
// Combinational ALU: produces a DW-bit result plus
// carry/borrow for one sequencer operation.
module rf_alu
    import rf_pkg::*;
#(
    parameter int W = rf_pkg::DW
) (
    input  op_e          op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] imm,
    output logic         carry,
    output logic [W-1:0] result
);

    logic [W:0] wide;

    // The extra top bit is carry for ADD and borrow for SUB.
    always_comb begin
        wide = '0;
        unique case (op)
            OP_ADD: wide = {1'b0, a} + {1'b0, b};
            OP_SUB: wide = {1'b0, a} - {1'b0, b};
            OP_AND: wide = {1'b0, a & b};
            OP_OR:  wide = {1'b0, a | b};
            OP_XOR: wide = {1'b0, a ^ b};
            OP_MOV: wide = {1'b0, a};
            OP_LDI: wide = {1'b0, imm};
            OP_NOP: wide = '0;
        endcase
    end

    assign carry  = wide[W];
    assign result = wide[W-1:0];

endmodule

// File: rtl/rf_op_sequencer.sv
// Four-state sequencer: accept, read operands, execute,
// then commit one result to the register file.
module rf_op_sequencer #(
    parameter int DW = rf_pkg::DW,
    parameter int AW = rf_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [AW-1:0] in_dst,
    input  logic [AW-1:0] in_src0,
    input  logic [AW-1:0] in_src1,
    input  logic [DW-1:0] in_imm,
    output logic [AW-1:0] rf_rd0_addr,
    output logic [AW-1:0] rf_rd1_addr,
    input  logic [DW-1:0] rf_rd0_data,
    input  logic [DW-1:0] rf_rd1_data,
    output logic          rf_wr_en,
    output logic [AW-1:0] rf_wr_addr,
    output logic [DW-1:0] rf_wr_data,
    output logic          done,
    output logic [DW-1:0] result,
    output logic          flag_c,
    output logic          flag_z
);

    import rf_pkg::*;

    logic [1:0]    state;
    op_e           req_op;
    logic [AW-1:0] req_dst;
    logic [DW-1:0] req_imm;
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic          alu_c;
    logic [DW-1:0] alu_r;

    assign in_ready = (state == ST_IDLE);

    rf_alu #(.W(DW)) u_alu (
        .op     (req_op),
        .a      (opa),
        .b      (opb),
        .imm    (req_imm),
        .carry  (alu_c),
        .result (alu_r)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            req_op      <= OP_NOP;
            req_dst     <= '0;
            req_imm     <= '0;
            opa         <= '0;
            opb         <= '0;
            rf_rd0_addr <= '0;
            rf_rd1_addr <= '0;
            rf_wr_en    <= 1'b0;
            rf_wr_addr  <= '0;
            rf_wr_data  <= '0;
            done        <= 1'b0;
            result      <= '0;
            flag_c      <= 1'b0;
            flag_z      <= 1'b0;
        end else begin
            done     <= 1'b0;
            rf_wr_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        req_op      <= op_e'(in_op);
                        req_dst     <= in_dst;
                        req_imm     <= in_imm;
                        rf_rd0_addr <= in_src0;
                        rf_rd1_addr <= in_src1;
                        state       <= ST_READ;
                    end
                end
                ST_READ: begin
                    opa   <= rf_rd0_data;
                    opb   <= rf_rd1_data;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    done  <= 1'b1;
                    state <= ST_WRITE;
                    // NOP retires without touching result or flags.
                    if (req_op != OP_NOP) begin
                        rf_wr_en   <= 1'b1;
                        rf_wr_addr <= req_dst;
                        rf_wr_data <= alu_r;
                        result     <= alu_r;
                        flag_c     <= alu_c;
                        flag_z     <= (alu_r == '0);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Directed bench: sequencer driving a 4x9 register file
// model with combinational reads and negedge writes.
module tb_rf_op_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_op = '0;
    logic [1:0] in_dst = '0;
    logic [1:0] in_src0 = '0;
    logic [1:0] in_src1 = '0;
    logic [8:0] in_imm = '0;
    logic [1:0] rf_rd0_addr;
    logic [1:0] rf_rd1_addr;
    logic [8:0] rf_rd0_data;
    logic [8:0] rf_rd1_data;
    logic       rf_wr_en;
    logic [1:0] rf_wr_addr;
    logic [8:0] rf_wr_data;
    logic       done;
    logic [8:0] result;
    logic       flag_c;
    logic       flag_z;

    logic [8:0] regs [4];

    int errors = 0;
    int checks = 0;
    bit last_wen;

    localparam logic [2:0] NOP = 3'd0;
    localparam logic [2:0] ADD = 3'd1;
    localparam logic [2:0] SUB = 3'd2;
    localparam logic [2:0] AND = 3'd3;
    localparam logic [2:0] OR  = 3'd4;
    localparam logic [2:0] XOR = 3'd5;
    localparam logic [2:0] MOV = 3'd6;
    localparam logic [2:0] LDI = 3'd7;

    always #5 clk = ~clk;

    rf_op_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_dst      (in_dst),
        .in_src0     (in_src0),
        .in_src1     (in_src1),
        .in_imm      (in_imm),
        .rf_rd0_addr (rf_rd0_addr),
        .rf_rd1_addr (rf_rd1_addr),
        .rf_rd0_data (rf_rd0_data),
        .rf_rd1_data (rf_rd1_data),
        .rf_wr_en    (rf_wr_en),
        .rf_wr_addr  (rf_wr_addr),
        .rf_wr_data  (rf_wr_data),
        .done        (done),
        .result      (result),
        .flag_c      (flag_c),
        .flag_z      (flag_z)
    );

    assign rf_rd0_data = regs[rf_rd0_addr];
    assign rf_rd1_data = regs[rf_rd1_addr];

    initial begin
        for (int i = 0; i < 4; i++) regs[i] = '0;
    end

    always @(negedge clk) begin
        if (rf_wr_en) regs[rf_wr_addr] <= rf_wr_data;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d",
                     tag, got, exp);
        end
    endtask

    task automatic run(input logic [2:0] op,
                       input logic [1:0] d,
                       input logic [1:0] s0,
                       input logic [1:0] s1,
                       input logic [8:0] imm);
        int lat;
        @(negedge clk);
        in_op    = op;
        in_dst   = d;
        in_src0  = s0;
        in_src1  = s1;
        in_imm   = imm;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        last_wen = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (rf_wr_en) last_wen = 1'b1;
            if (done) begin
                lat = k;
                break;
            end
        end
        check("latency", lat, 3);
    endtask

    logic [2:0] bop [3];
    logic [1:0] bdst [3];
    logic [8:0] bimm [3];
    int opidx;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", in_ready, 1);
        check("rst_wr_en", rf_wr_en, 0);
        check("rst_done", done, 0);
        check("rst_rd0", rf_rd0_addr, 0);
        check("rst_rd1", rf_rd1_addr, 0);
        check("rst_wa", rf_wr_addr, 0);
        check("rst_wd", rf_wr_data, 0);
        check("rst_result", result, 0);
        check("rst_c", flag_c, 0);
        check("rst_z", flag_z, 0);
        @(negedge clk);
        rst = 1'b0;

        run(LDI, 2'd0, 2'd0, 2'd0, 9'd55);
        check("ldi_res", result, 55);
        run(LDI, 2'd1, 2'd0, 2'd0, 9'd25);
        run(ADD, 2'd2, 2'd0, 2'd1, 9'd0);
        check("add_res", result, 80);
        check("add_c", flag_c, 0);
        check("add_z", flag_z, 0);
        check("add_wen", last_wen, 1);
        @(negedge clk);
        check("rf_r2", regs[2], 80);

        run(AND, 2'd3, 2'd0, 2'd1, 9'd0);
        check("and_res", result, 17);
        run(OR, 2'd3, 2'd0, 2'd1, 9'd0);
        check("or_res", result, 63);
        run(XOR, 2'd3, 2'd0, 2'd1, 9'd0);
        check("xor_res", result, 46);
        run(MOV, 2'd3, 2'd0, 2'd1, 9'd0);
        check("mov_res", result, 55);

        run(ADD, 2'd2, 2'd0, 2'd1, 9'd0);
        run(NOP, 2'd2, 2'd0, 2'd0, 9'd0);
        check("nop_wen", last_wen, 0);
        check("nop_res", result, 80);
        check("nop_c", flag_c, 0);

        run(LDI, 2'd0, 2'd0, 2'd0, 9'd500);
        run(LDI, 2'd1, 2'd0, 2'd0, 9'd20);
        run(ADD, 2'd3, 2'd0, 2'd1, 9'd0);
        check("addc_res", result, 8);
        check("addc_c", flag_c, 1);
        check("addc_z", flag_z, 0);
        @(negedge clk);
        check("rf_r3", regs[3], 8);

        run(LDI, 2'd0, 2'd0, 2'd0, 9'd25);
        run(LDI, 2'd1, 2'd0, 2'd0, 9'd30);
        run(SUB, 2'd2, 2'd0, 2'd1, 9'd0);
        check("sub_res", result, 507);
        check("sub_c", flag_c, 1);
        run(SUB, 2'd3, 2'd1, 2'd1, 9'd0);
        check("subz_res", result, 0);
        check("subz_z", flag_z, 1);
        check("subz_c", flag_c, 0);

        bop[0] = LDI; bdst[0] = 2'd0; bimm[0] = 9'd7;
        bop[1] = LDI; bdst[1] = 2'd1; bimm[1] = 9'd9;
        bop[2] = ADD; bdst[2] = 2'd2; bimm[2] = 9'd0;
        opidx = 0;
        @(negedge clk);
        for (int i = 0; i <= 12; i++) begin
            if (i > 0) @(negedge clk);
            check("b2b_ready", in_ready, (i % 4) == 0);
            check("b2b_done", done, (i % 4) == 3);
            check("b2b_wen", rf_wr_en, (i % 4) == 3);
            if (in_ready && opidx < 3) begin
                in_op    = bop[opidx];
                in_dst   = bdst[opidx];
                in_src0  = 2'd0;
                in_src1  = 2'd1;
                in_imm   = bimm[opidx];
                in_valid = 1'b1;
                opidx++;
            end else if (in_ready) begin
                in_valid = 1'b0;
            end
        end
        check("b2b_res", result, 16);
        check("b2b_r2", regs[2], 16);

        run(LDI, 2'd2, 2'd0, 2'd0, 9'd30);
        run(LDI, 2'd0, 2'd0, 2'd0, 9'd5);
        run(LDI, 2'd1, 2'd0, 2'd0, 9'd6);
        @(negedge clk);
        in_op    = ADD;
        in_dst   = 2'd2;
        in_src0  = 2'd1;
        in_src1  = 2'd0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_ready", in_ready, 1);
        check("mid_wen", rf_wr_en, 0);
        check("mid_done", done, 0);
        check("mid_rd0", rf_rd0_addr, 0);
        check("mid_res", result, 0);
        check("mid_c", flag_c, 0);
        repeat (3) @(negedge clk);
        check("mid_wen2", rf_wr_en, 0);
        rst = 1'b0;
        check("mid_r2", regs[2], 30);
        run(ADD, 2'd2, 2'd1, 2'd0, 9'd0);
        check("post_res", result, 11);
        @(negedge clk);
        check("post_r2", regs[2], 11);

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
